// File: rtl/pool_window_gather.sv
// -----------------------------------------------------------------------------
// pool_window_gather
//
// Streaming 2x2 window gatherer feeding the pooling unit. Pixels arrive one per
// accepted cycle in raster order. Even rows are parked in a one-row line
// buffer. On odd rows each pair of pixels is combined with the two buffered
// pixels above it, and the result is presented as a single 2x2 window with a
// one-cycle strobe. Windows do not overlap (stride 2). A trailing odd column,
// and a trailing odd row, are counted but never used.
//
// Optional feature (compile-time macro): POOL_WIN_SOF_EN
//   When defined, an extra sof_in input restarts the frame. An accepted pixel
//   with sof_in high is treated as pixel (0,0), and any partial frame in
//   progress is abandoned without a frame_done pulse.
//
// Parameters
//   IMG_WIDTH   pixels per row   (>= 2)
//   IMG_HEIGHT  rows per frame   (>= 2)
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   pixel_in    signed 16-bit pixel
//   valid_in    pixel_in is consumed this cycle (no backpressure)
//   sof_in      start-of-frame marker (POOL_WIN_SOF_EN only)
//   win0..win3  window: top-left, top-right, bottom-left, bottom-right
//   win_valid   one-cycle strobe, win0..win3 hold a fresh window
//   frame_done  one-cycle strobe, last pixel of the frame was consumed
// -----------------------------------------------------------------------------
module pool_window_gather #(
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] pixel_in,
    input  logic               valid_in,
`ifdef POOL_WIN_SOF_EN
    input  logic               sof_in,
`endif
    output logic signed [15:0] win0,
    output logic signed [15:0] win1,
    output logic signed [15:0] win2,
    output logic signed [15:0] win3,
    output logic               win_valid,
    output logic               frame_done
);

    localparam int COL_W = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [COL_W-1:0] LAST_COL   = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0] PENULT_ROW = ROW_W'(IMG_HEIGHT - 2);
    localparam logic [COL_W-1:0] COL_ONE    = COL_W'(1);
    localparam logic [ROW_W-1:0] ROW_ONE    = ROW_W'(1);

    // TOP    : even row, pixels go into the line buffer
    // BOTTOM : odd row, pixel pairs complete windows
    // DROP   : unpaired last row of an odd-height frame, counted only
    typedef enum logic [1:0] {
        TOP    = 2'd0,
        BOTTOM = 2'd1,
        DROP   = 2'd2
    } state_t;

    state_t             state;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic signed [15:0] left_reg;
    logic signed [15:0] line_buf [IMG_WIDTH];

    // Effective position of the current pixel (after any start-of-frame
    // override) and the position/state it leads to.
    state_t             cur_state;
    state_t             next_state;
    logic [COL_W-1:0]   cur_col;
    logic [ROW_W-1:0]   cur_row;
    logic [ROW_W-1:0]   next_row;
    logic [COL_W-1:0]   pair_col;
    logic               at_last_col;
    logic               at_last_row;
    logic               completes_window;
    logic               takes_left;
    logic signed [15:0] lb_left;
    logic signed [15:0] lb_right;

    // NOTE: every signal assigned in this block receives a default value
    // first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        cur_state = state;
        cur_col   = col;
        cur_row   = row;
`ifdef POOL_WIN_SOF_EN
        // Only meaningful when the pixel is actually accepted; every use
        // below is qualified by valid_in.
        if (sof_in) begin
            cur_state = TOP;
            cur_col   = '0;
            cur_row   = '0;
        end
`endif
        at_last_col = (cur_col == LAST_COL);
        at_last_row = (cur_row == LAST_ROW);

        next_row = at_last_row ? '0 : cur_row + ROW_ONE;

        next_state = cur_state;
        if (at_last_col) begin
            case (cur_state)
                TOP:    next_state = BOTTOM;
                BOTTOM: begin
                    if (at_last_row)
                        next_state = TOP;      // frame complete
                    else if (cur_row == PENULT_ROW)
                        next_state = DROP;     // one unpaired row remains
                    else
                        next_state = TOP;
                end
                DROP:   next_state = TOP;
                default: next_state = TOP;
            endcase
        end

        // Odd columns close a window; even columns supply its left half.
        // For an odd width the final (even) column only touches left_reg,
        // which is overwritten before it is ever used again.
        completes_window = (cur_state == BOTTOM) &&  cur_col[0];
        takes_left       = (cur_state == BOTTOM) && !cur_col[0];

        // Even partner of the current column; always in range.
        pair_col = cur_col & ~COL_ONE;
        lb_left  = line_buf[pair_col];
        lb_right = line_buf[cur_col];
    end

    // NOTE: the line buffer has no reset. Every entry is written on a TOP
    // row before the following BOTTOM row reads it, so clearing it would
    // only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (!rst && valid_in && cur_state == TOP)
            line_buf[cur_col] <= pixel_in;
    end

    // Position counters, row-parity FSM and registered window outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= TOP;
            col        <= '0;
            row        <= '0;
            left_reg   <= '0;
            win0       <= '0;
            win1       <= '0;
            win2       <= '0;
            win3       <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;

            if (valid_in) begin
                if (at_last_col) begin
                    col   <= '0;
                    row   <= next_row;
                    state <= next_state;
                end else begin
                    col   <= cur_col + COL_ONE;
                    row   <= cur_row;
                    state <= cur_state;
                end

                if (takes_left)
                    left_reg <= pixel_in;

                if (completes_window) begin
                    win0      <= lb_left;
                    win1      <= lb_right;
                    win2      <= left_reg;
                    win3      <= pixel_in;
                    win_valid <= 1'b1;
                end

                frame_done <= at_last_col && at_last_row;
            end
        end
    end

endmodule

// File: tb/tb_pool_window_gather.sv
// -----------------------------------------------------------------------------
// tb_pool_window_gather
//
// Two instances: a 4x4 frame (dut index 0) and a 5x3 frame (dut index 1, odd
// width and odd height). A reference model stores each accepted pixel at its
// (row, col) in an image array and derives windows and frame ends directly
// from coordinates. Expected events go into a scoreboard queue; a monitor on
// the falling edge pops and compares whenever a strobe appears, and between
// strobes checks that the window outputs hold their last value.
// -----------------------------------------------------------------------------
module tb_pool_window_gather;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_v   [2];
    logic               valid_v [2];
    logic signed [15:0] pix_v   [2];
`ifdef POOL_WIN_SOF_EN
    logic               sof_v   [2];
`endif

    logic signed [15:0] a_w0, a_w1, a_w2, a_w3, b_w0, b_w1, b_w2, b_w3;
    logic               a_wv, a_fd, b_wv, b_fd;

    pool_window_gather #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_a (
        .clk        (clk),
        .rst        (rst_v[0]),
        .pixel_in   (pix_v[0]),
        .valid_in   (valid_v[0]),
`ifdef POOL_WIN_SOF_EN
        .sof_in     (sof_v[0]),
`endif
        .win0       (a_w0),
        .win1       (a_w1),
        .win2       (a_w2),
        .win3       (a_w3),
        .win_valid  (a_wv),
        .frame_done (a_fd)
    );

    pool_window_gather #(.IMG_WIDTH(5), .IMG_HEIGHT(3)) dut_b (
        .clk        (clk),
        .rst        (rst_v[1]),
        .pixel_in   (pix_v[1]),
        .valid_in   (valid_v[1]),
`ifdef POOL_WIN_SOF_EN
        .sof_in     (sof_v[1]),
`endif
        .win0       (b_w0),
        .win1       (b_w1),
        .win2       (b_w2),
        .win3       (b_w3),
        .win_valid  (b_wv),
        .frame_done (b_fd)
    );

    // Observed outputs gathered per dut index.
    logic [63:0] obs_win [2];
    logic        obs_wv  [2];
    logic        obs_fd  [2];
    always_comb begin
        obs_win[0] = {a_w0, a_w1, a_w2, a_w3};
        obs_win[1] = {b_w0, b_w1, b_w2, b_w3};
        obs_wv[0]  = a_wv;
        obs_wv[1]  = b_wv;
        obs_fd[0]  = a_fd;
        obs_fd[1]  = b_fd;
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        int          dut;
        bit          win;
        bit          fd;
        logic [63:0] px;
    } exp_t;

    exp_t               sbq[$];
    logic signed [15:0] img [2][8][8];
    int                 mrow [2];
    int                 mcol [2];
    int                 ncomp;
    int                 nfail;
    bit                 mon_en;

    function automatic int img_w(input int d);
        return (d == 0) ? 4 : 5;
    endfunction

    function automatic int img_h(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    task automatic model_accept(input int d, input logic signed [15:0] val, input bit s);
        int   r;
        int   c;
        int   w;
        int   h;
        exp_t e;
        w = img_w(d);
        h = img_h(d);
        if (s) begin
            mrow[d] = 0;
            mcol[d] = 0;
        end
        r = mrow[d];
        c = mcol[d];
        img[d][r][c] = val;
        e.dut = d;
        e.win = (r % 2 == 1) && (c % 2 == 1) && (r < 2 * (h / 2)) && (c < 2 * (w / 2));
        e.fd  = (r == h - 1) && (c == w - 1);
        e.px  = '0;
        if (e.win)
            e.px = {img[d][r-1][c-1], img[d][r-1][c], img[d][r][c-1], val};
        if (e.win || e.fd)
            sbq.push_back(e);
        c++;
        if (c == w) begin
            c = 0;
            r = (r + 1) % h;
        end
        mrow[d] = r;
        mcol[d] = c;
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic drive(input int d, input bit v, input logic signed [15:0] val, input bit s);
        valid_v[d] = v;
        pix_v[d]   = val;
`ifdef POOL_WIN_SOF_EN
        sof_v[d]   = s;
        if (v) model_accept(d, val, s);
`else
        if (v) model_accept(d, val, 1'b0);
`endif
        @(posedge clk);
        #1;
        valid_v[d] = 1'b0;
`ifdef POOL_WIN_SOF_EN
        sof_v[d]   = 1'b0;
`endif
    endtask

    // Reset with a live pixel alongside it: the pixel must be discarded.
    task automatic do_reset(input int d);
        rst_v[d]   = 1'b1;
        valid_v[d] = 1'b1;
        pix_v[d]   = 16'sh7abc;
        @(posedge clk);
        #1;
        rst_v[d]   = 1'b0;
        valid_v[d] = 1'b0;
        mrow[d]    = 0;
        mcol[d]    = 0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncomp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic        rst_s [2];
    logic [63:0] held  [2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) rst_s[d] = rst_v[d];
    end

    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                if (rst_s[d]) begin
                    check($sformatf("reset_state_dut%0d", d),
                          {obs_win[d][61:0], obs_wv[d], obs_fd[d]}, 64'd0);
                    check($sformatf("reset_win_hi_dut%0d", d), {62'd0, obs_win[d][63:62]}, 64'd0);
                    held[d] = '0;
                end else if (obs_wv[d] || obs_fd[d]) begin
                    if (sbq.size() == 0 || sbq[0].dut != d) begin
                        ncomp++;
                        nfail++;
                        $display("FAIL unexpected_strobe_dut%0d: got win_valid=%0b frame_done=%0b, expected no strobe (t=%0t)",
                                 d, obs_wv[d], obs_fd[d], $time);
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        check($sformatf("win_valid_dut%0d", d), {63'd0, obs_wv[d]}, {63'd0, e.win});
                        check($sformatf("frame_done_dut%0d", d), {63'd0, obs_fd[d]}, {63'd0, e.fd});
                        if (e.win) begin
                            check($sformatf("window_dut%0d", d), obs_win[d], e.px);
                            held[d] = e.px;
                        end else begin
                            check($sformatf("hold_dut%0d", d), obs_win[d], held[d]);
                        end
                    end
                end else begin
                    check($sformatf("hold_dut%0d", d), obs_win[d], held[d]);
                end
            end
        end
    end

    // Expected strobes that never appear are caught by the final queue check;
    // this bounds the run regardless.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        ncomp  = 0;
        nfail  = 0;
        mon_en = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rst_v[d]   = 1'b1;
            valid_v[d] = 1'b0;
            pix_v[d]   = '0;
`ifdef POOL_WIN_SOF_EN
            sof_v[d]   = 1'b0;
`endif
            mrow[d]    = 0;
            mcol[d]    = 0;
            held[d]    = '0;
            rst_s[d]   = 1'b1;
        end
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        for (int d = 0; d < 2; d++) rst_v[d] = 1'b0;

        // 4x4 back-to-back, pixels 0..15
        for (int i = 0; i < 16; i++) drive(0, 1'b1, 16'(i), 1'b0);

        // 5x3, pixels 0..14: two windows, DROP row, frame_done after 14
        for (int i = 0; i < 15; i++) drive(1, 1'b1, 16'(i), 1'b0);

        // 4x4 with alternating gaps and signed values -8..7; junk on idle cycles
        for (int i = 0; i < 16; i++) begin
            drive(0, 1'b1, 16'(i - 8), 1'b0);
            drive(0, 1'b0, 16'sh5a5a, 1'b0);
        end

        // Reset after pixel 6, then a fresh frame 100..115
        for (int i = 0; i < 7; i++) drive(0, 1'b1, 16'(i), 1'b0);
        do_reset(0);
        for (int i = 0; i < 16; i++) drive(0, 1'b1, 16'(100 + i), 1'b0);

`ifdef POOL_WIN_SOF_EN
        // Abandoned partial frame, a lone sof without valid, then a restart
        for (int i = 0; i < 3; i++) drive(0, 1'b1, 16'(200 + i), 1'b0);
        drive(0, 1'b0, 16'sh1234, 1'b1);
        drive(0, 1'b1, 16'sd50, 1'b1);
        for (int i = 51; i < 66; i++) drive(0, 1'b1, 16'(i), 1'b0);
`endif

        // Two consecutive 4x4 frames, random data, no gap
        for (int i = 0; i < 32; i++) drive(0, 1'b1, 16'($urandom), 1'b0);

        // Randomised traffic with gaps on the 5x3 instance
        for (int i = 0; i < 200; i++)
            drive(1, ($urandom_range(0, 2) != 0), 16'($urandom), 1'b0);

        // Randomised traffic on the 4x4 instance with occasional resets
        // (and occasional start-of-frame when that feature is built)
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 59) == 0)
                do_reset(0);
            else
                drive(0, ($urandom_range(0, 3) != 0), 16'($urandom),
                      ($urandom_range(0, 39) == 0));
        end

        repeat (4) @(posedge clk);
        #1;
        ncomp++;
        if (sbq.size() != 0) begin
            nfail++;
            $display("FAIL scoreboard_drain: got %0d pending events, expected 0", sbq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
